vermidma: RTL and testbench

- Vermibus initiator that copies a block of 32-bit words from a source address to a destination address.
- It drives one read-write request port: one read, then one write, per word.
- Sits beside the CPU as a second dbus initiator, behind an external arbiter, and targets RAM or devices such as the text output and tick counter.
- Lets benchmarks move data without CPU load/store loops.

---
 rtl/vermidma_pkg.sv | 20 ++
 rtl/vermidma.sv | 161 ++++++++++++++++
 tb/tb_vermidma.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vermidma_pkg.sv
// Shared types and constants for the vermidma block-copy initiator.
package vermidma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0]  WSTROBE_READ = 4'b0000;
   localparam logic [3:0]  WSTROBE_WORD = 4'b1111;
   localparam logic [31:0] ADDR_STEP    = 32'd4;

   // Clear the byte-offset bits so every request is word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/vermidma.sv
// vermidma: Vermibus initiator copying a block of 32-bit words, one read
// then one write per word. All bus-facing outputs are registered and are
// updated together with the state, so a request is stable until accepted.
// Optional fill mode (constant-value writes, no reads) is enabled by
// defining VERMIDMA_FILL_EN.
module vermidma
   import vermidma_pkg::*;
#(
   parameter int LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [31:0]          src,
   input  logic [31:0]          dst,
   input  logic [LEN_WIDTH-1:0] len,
`ifdef VERMIDMA_FILL_EN
   input  logic                 fill,
   input  logic [31:0]          fill_value,
`endif
   output logic                 busy,
   output logic                 done,
   output logic                 bus_valid,
   input  logic                 bus_ready,
   output logic [31:0]          bus_address,
   output logic [3:0]           bus_wstrobe,
   output logic [31:0]          bus_wdata,
   input  logic [31:0]          bus_rdata
);

   localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
   localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1'b1);

   state_t                 state;
   logic [31:0]            src_ptr;
   logic [31:0]            dst_ptr;
   logic [LEN_WIDTH-1:0]   remaining;

   logic [31:0]            src_next;
   logic [31:0]            dst_next;
   logic                   last_word;
   logic                   fill_mode;
   logic                   start_fill;
   logic [31:0]            start_wdata;

   assign src_next  = src_ptr + ADDR_STEP;
   assign dst_next  = dst_ptr + ADDR_STEP;
   assign last_word = (remaining == LEN_ONE);

`ifdef VERMIDMA_FILL_EN
   assign start_fill  = fill;
   assign start_wdata = fill ? fill_value : bus_wdata;

   // Remember whether the accepted transfer is a fill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_mode <= 1'b0;
      end else if (state == IDLE && start) begin
         fill_mode <= fill;
      end else begin
         fill_mode <= fill_mode;
      end
   end
`else
   assign start_fill  = 1'b0;
   assign start_wdata = bus_wdata;
   assign fill_mode   = 1'b0;
`endif

   // Transfer FSM with pointers, word counter and registered bus outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         src_ptr     <= 32'd0;
         dst_ptr     <= 32'd0;
         remaining   <= LEN_ZERO;
         busy        <= 1'b0;
         done        <= 1'b0;
         bus_valid   <= 1'b0;
         bus_address <= 32'd0;
         bus_wstrobe <= WSTROBE_READ;
         bus_wdata   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  src_ptr   <= word_align(src);
                  dst_ptr   <= word_align(dst);
                  remaining <= len;
                  busy      <= 1'b1;
                  bus_wdata <= start_wdata;
                  if (len == LEN_ZERO) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     bus_valid <= 1'b0;
                  end else if (start_fill) begin
                     state       <= WRITE;
                     bus_valid   <= 1'b1;
                     bus_address <= word_align(dst);
                     bus_wstrobe <= WSTROBE_WORD;
                  end else begin
                     state       <= READ;
                     bus_valid   <= 1'b1;
                     bus_address <= word_align(src);
                     bus_wstrobe <= WSTROBE_READ;
                  end
               end else begin
                  busy      <= 1'b0;
                  bus_valid <= 1'b0;
               end
            end
            READ: begin
               if (bus_ready) begin
                  src_ptr     <= src_next;
                  bus_wdata   <= bus_rdata;
                  bus_address <= dst_ptr;
                  bus_wstrobe <= WSTROBE_WORD;
                  state       <= WRITE;
               end else begin
                  state <= READ;
               end
            end
            WRITE: begin
               if (bus_ready) begin
                  dst_ptr   <= dst_next;
                  remaining <= remaining - LEN_ONE;
                  if (last_word) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     bus_valid   <= 1'b0;
                     bus_wstrobe <= WSTROBE_READ;
                  end else if (fill_mode) begin
                     state       <= WRITE;
                     bus_address <= dst_next;
                  end else begin
                     state       <= READ;
                     bus_address <= src_ptr;
                     bus_wstrobe <= WSTROBE_READ;
                  end
               end else begin
                  state <= WRITE;
               end
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               bus_valid <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               bus_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vermidma.sv
// Self-checking bench for vermidma: a small word memory answers the bus,
// a scoreboard queue holds the expected request sequence, and a reference
// memory model holds the expected final contents.
module tb_vermidma;
   import vermidma_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] src;
   logic [31:0] dst;
   logic [15:0] len;
`ifdef VERMIDMA_FILL_EN
   logic        fill;
   logic [31:0] fill_value;
`endif
   logic        busy;
   logic        done;
   logic        bus_valid;
   logic        bus_ready;
   logic [31:0] bus_address;
   logic [3:0]  bus_wstrobe;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   logic [31:0] mem   [0:255];
   logic [31:0] model [0:255];
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_data;

   txn_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          done_cnt = 0;
   int          done_at = -1;
   int          stall = 0;
   bit          bp_mode = 1'b0;
   bit          busy_exp = 1'b0;
   bit          prev_pend = 1'b0;
   logic [31:0] prev_addr;
   logic [31:0] prev_wdata;
   logic [3:0]  prev_strb;

   vermidma #(.LEN_WIDTH(16)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .src(src),
      .dst(dst),
      .len(len),
`ifdef VERMIDMA_FILL_EN
      .fill(fill),
      .fill_value(fill_value),
`endif
      .busy(busy),
      .done(done),
      .bus_valid(bus_valid),
      .bus_ready(bus_ready),
      .bus_address(bus_address),
      .bus_wstrobe(bus_wstrobe),
      .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // Memory responder: bench preload port or accepted bus writes.
   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      else if (bus_valid && bus_ready && bus_wstrobe == 4'hF) mem[bus_address[9:2]] <= bus_wdata;
   end

   assign bus_rdata = mem[bus_address[9:2]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = addr[9:2];
      pre_data = data;
      model[addr[9:2]] = data;
   endtask

   task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n,
                           input bit fl, input logic [31:0] fv);
      @(negedge clk);
      cyc++;
      start = 1'b1;
      src = s;
      dst = d;
      len = 16'(n);
`ifdef VERMIDMA_FILL_EN
      fill = fl;
      fill_value = fv;
`else
      if (fl) $display("note: fill requested but not built, value %08h", fv);
`endif
      bus_ready = 1'b1;
      start_cyc = cyc;
      prev_pend = 1'b0;
      busy_exp = 1'b1;
      done_cnt = 0;
      done_at = -1;
      stall = 0;
      #1;
   endtask

   task automatic run_cycle();
      txn_t t;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (bp_mode) begin
         if (stall > 0) begin
            bus_ready = 1'b0;
            stall--;
         end else begin
            bus_ready = 1'b1;
            stall = $urandom_range(0, 3);
         end
      end else begin
         bus_ready = 1'b1;
      end
      #1;
      if (prev_pend) begin
         check("hold_valid", 32'(bus_valid), 32'd1);
         check("hold_addr", bus_address, prev_addr);
         check("hold_wstrobe", 32'(bus_wstrobe), 32'(prev_strb));
         check("hold_wdata", bus_wdata, prev_wdata);
      end
      prev_pend  = bus_valid && !bus_ready;
      prev_addr  = bus_address;
      prev_strb  = bus_wstrobe;
      prev_wdata = bus_wdata;
      check("busy", 32'(busy), 32'(busy_exp));
      if (done) begin
         done_cnt++;
         done_at = cyc;
         busy_exp = 1'b0;
      end
      if (bus_valid && bus_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_request observed=0x%08h expected=no request", bus_address);
         end
         if (sb.size() != 0) begin
            t = sb.pop_front();
            check("req_addr", bus_address, t.addr);
            check("req_wstrobe", 32'(bus_wstrobe), 32'(t.strb));
            if (t.strb == 4'hF) check("req_wdata", bus_wdata, t.data);
         end
      end
   endtask

   task automatic transfer(input logic [31:0] s, input logic [31:0] d, input int n,
                           input bit bp, input bit fl, input logic [31:0] fv, input int lat);
      logic [31:0] sa;
      logic [31:0] da;
      logic [31:0] rd;
      txn_t t;
      sa = s & 32'hFFFF_FFFC;
      da = d & 32'hFFFF_FFFC;
      for (int i = 0; i < n; i++) begin
         if (fl) begin
            rd = fv;
         end else begin
            rd = model[sa[9:2]];
            t.addr = sa; t.strb = 4'h0; t.data = 32'd0;
            sb.push_back(t);
            sa = sa + 32'd4;
         end
         t.addr = da; t.strb = 4'hF; t.data = rd;
         sb.push_back(t);
         model[da[9:2]] = rd;
         da = da + 32'd4;
      end
      do_start(s, d, n, fl, fv);
      bp_mode = bp;
      for (int k = 0; k < 400 && !(done_cnt > 0 && cyc > done_at); k++) run_cycle();
      bp_mode = 1'b0;
      check("done_count", 32'(done_cnt), 32'd1);
      if (!bp) check("latency", 32'(done_at - start_cyc), 32'(lat));
      check("sb_empty", 32'(sb.size()), 32'd0);
      da = d & 32'hFFFF_FFFC;
      for (int i = 0; i < n; i++) begin
         check("mem_word", mem[da[9:2]], model[da[9:2]]);
         da = da + 32'd4;
      end
   endtask

   initial begin
      txn_t t;
      reset = 1'b1; start = 1'b0; src = 32'd0; dst = 32'd0; len = 16'd0;
`ifdef VERMIDMA_FILL_EN
      fill = 1'b0; fill_value = 32'd0;
`endif
      bus_ready = 1'b0; pre_we = 1'b0; pre_idx = 8'd0; pre_data = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(bus_valid), 32'd0);
      check("rst_addr", bus_address, 32'd0);
      check("rst_wstrobe", 32'(bus_wstrobe), 32'd0);
      check("rst_wdata", bus_wdata, 32'd0);
      reset = 1'b0;

      preload(32'h100, 32'd1);
      preload(32'h104, 32'd2);
      preload(32'h108, 32'd3);
      preload(32'h10C, 32'd4);
      preload(32'h244, 32'hA5A5_A5A5);
      preload(32'hFFFF_FFFC, 32'h1111_1111);
      preload(32'h0000_0000, 32'h2222_2222);
      @(negedge clk);
      pre_we = 1'b0;

      // Plain copy with ready held high: 2N+1 cycles.
      transfer(32'h100, 32'h200, 4, 1'b0, 1'b0, 32'd0, 9);
      // Random backpressure on the same source block.
      transfer(32'h100, 32'h2C0, 4, 1'b1, 1'b0, 32'd0, 0);

      // Zero length, with a start pulse presented while in DONE.
      do_start(32'h100, 32'h3A0, 0, 1'b0, 32'd0);
      run_cycle();
      check("len0_latency", 32'(done_at - start_cyc), 32'd1);
      start = 1'b1;
      len = 16'd5;
      repeat (4) run_cycle();
      check("len0_done_count", 32'(done_cnt), 32'd1);

      // Misaligned source wrapping past the top of the address space.
      transfer(32'hFFFF_FFFE, 32'h180, 2, 1'b0, 1'b0, 32'd0, 5);

      // Reset during the second write while the responder stalls.
      t.addr = 32'h100; t.strb = 4'h0; t.data = 32'd0; sb.push_back(t);
      t.addr = 32'h240; t.strb = 4'hF; t.data = 32'd1; sb.push_back(t);
      t.addr = 32'h104; t.strb = 4'h0; t.data = 32'd0; sb.push_back(t);
      model[8'h90] = 32'd1;
      do_start(32'h100, 32'h240, 4, 1'b0, 32'd0);
      repeat (3) run_cycle();
      @(negedge clk);
      cyc++;
      bus_ready = 1'b0;
      #1;
      check("mid_valid", 32'(bus_valid), 32'd1);
      check("mid_addr", bus_address, 32'h244);
      reset = 1'b1;
      #1;
      check("arst_valid", 32'(bus_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_state", 32'(dut.state), 32'(IDLE));
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      busy_exp = 1'b0;
      done_cnt = 0;
      prev_pend = 1'b0;
      repeat (3) run_cycle();
      check("arst_no_done", 32'(done_cnt), 32'd0);
      check("arst_kept_word", mem[8'h90], model[8'h90]);
      check("arst_untouched", mem[8'h91], model[8'h91]);
      transfer(32'h100, 32'h280, 4, 1'b0, 1'b0, 32'd0, 9);

`ifdef VERMIDMA_FILL_EN
      // Fill: writes only, N+1 cycles.
      transfer(32'h0, 32'h300, 3, 1'b0, 1'b1, 32'hDEAD_BEEF, 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
